edge_event_bank: RTL



---
 rtl/unicone_util_defs.sv | 28 ++
 rtl/edge_event_channel.sv | 102 ++++++++++
 rtl/edge_event_bank.sv | 77 +++++++
 3 files changed

// File: rtl/unicone_util_defs.sv
// ============================================================================
// Module  : unicone_util_defs (package)
// Brief   : Shared constant helpers and defaults for Unicone front-end blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package unicone_util_defs;

   localparam int c_DEFAULT_SYNC_STAGES   = 2;
   localparam int c_DEFAULT_FILTER_CYCLES = 4;

   // Ceiling log2, usable in parameter and localparam expressions.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/edge_event_channel.sv
// ============================================================================
// Module  : edge_event_channel
// Brief   : One channel: synchroniser, glitch filter, edge detector, sticky
//           flag and (with EDGE_EVENT_BANK_COUNT_EN) a saturating counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_event_channel
   import unicone_util_defs::*;
#(
   parameter int   SYNC_STAGES   = c_DEFAULT_SYNC_STAGES,
   parameter int   FILTER_CYCLES = c_DEFAULT_FILTER_CYCLES,
   parameter logic INIT_LEVEL    = 1'b0,
   parameter int   COUNT_BITS    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in,
   input  logic                  rise_en,
   input  logic                  fall_en,
   input  logic                  flag_clear,
   output logic                  level,
   output logic                  edge_pulse,
`ifdef EDGE_EVENT_BANK_COUNT_EN
   output logic [COUNT_BITS-1:0] count,
`endif
   output logic                  flag
);

   localparam int                 c_CNT_W    = clog2(FILTER_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [c_CNT_W-1:0]     w_cnt_nxt;
   logic                   r_level;
   logic                   w_level_nxt;
   logic                   w_sync;
   logic                   w_hit;
   logic                   r_pulse;
   logic                   r_flag;

   always_comb begin
      w_sync      = r_sync[SYNC_STAGES-1];
      w_level_nxt = r_level;
      w_cnt_nxt   = '0;
      if (w_sync != r_level) begin
         if (r_cnt == c_CNT_LAST) begin
            w_level_nxt = w_sync;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
      w_hit = (w_level_nxt != r_level) &&
              ((w_level_nxt && rise_en) || (!w_level_nxt && fall_en));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync  <= {SYNC_STAGES{INIT_LEVEL}};
         r_level <= INIT_LEVEL;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
         r_flag  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], in};
         r_level <= w_level_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pulse <= w_hit;
         // A new event outranks a clear arriving in the same cycle.
         if (w_hit) begin
            r_flag <= 1'b1;
         end else if (flag_clear) begin
            r_flag <= 1'b0;
         end
      end
   end

`ifdef EDGE_EVENT_BANK_COUNT_EN
   logic [COUNT_BITS-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (flag_clear) begin
         r_count <= COUNT_BITS'(w_hit);
      end else if (w_hit && (r_count != {COUNT_BITS{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;
`endif

   assign level      = r_level;
   assign edge_pulse = r_pulse;
   assign flag       = r_flag;

endmodule

`default_nettype wire

// File: rtl/edge_event_bank.sv
// ============================================================================
// Module  : edge_event_bank
// Brief   : Multi-channel synchronised, filtered edge detector with sticky
//           flags. Define EDGE_EVENT_BANK_COUNT_EN for per-channel counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_event_bank
   import unicone_util_defs::*;
#(
   parameter int                  CHANNELS      = 8,
   parameter int                  SYNC_STAGES   = c_DEFAULT_SYNC_STAGES,
   parameter int                  FILTER_CYCLES = c_DEFAULT_FILTER_CYCLES,
   parameter logic [CHANNELS-1:0] INIT_LEVEL    = {CHANNELS{1'b0}},
   parameter int                  COUNT_BITS    = 8,
   localparam int                 SEL_W         = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   in,
   input  logic [CHANNELS-1:0]   rise_en,
   input  logic [CHANNELS-1:0]   fall_en,
   input  logic [CHANNELS-1:0]   flag_clear,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   edge_pulse,
`ifdef EDGE_EVENT_BANK_COUNT_EN
   input  logic [SEL_W-1:0]      count_sel,
   output logic [COUNT_BITS-1:0] count_out,
`endif
   output logic [CHANNELS-1:0]   flags
);

   if (CHANNELS < 1 || CHANNELS > 32 || SYNC_STAGES < 2 ||
       FILTER_CYCLES < 1 || COUNT_BITS < 1) begin : g_param_check
      $error("edge_event_bank: parameter out of range");
   end

`ifdef EDGE_EVENT_BANK_COUNT_EN
   logic [COUNT_BITS-1:0] w_counts [CHANNELS];
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      edge_event_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES),
         .INIT_LEVEL    (INIT_LEVEL[i]),
         .COUNT_BITS    (COUNT_BITS)
      ) u_channel (
         .clk        (clk),
         .reset      (reset),
         .in         (in[i]),
         .rise_en    (rise_en[i]),
         .fall_en    (fall_en[i]),
         .flag_clear (flag_clear[i]),
         .level      (level[i]),
         .edge_pulse (edge_pulse[i]),
`ifdef EDGE_EVENT_BANK_COUNT_EN
         .count      (w_counts[i]),
`endif
         .flag       (flags[i])
      );
   end

`ifdef EDGE_EVENT_BANK_COUNT_EN
   // Selects beyond the last channel read as zero rather than aliasing.
   always_comb begin
      count_out = '0;
      if (32'(count_sel) < CHANNELS) begin
         count_out = w_counts[count_sel];
      end
   end
`endif

endmodule

`default_nettype wire
